// File: rtl/axi_master_arbiter_if.sv
// Bundle between the two-requester arbiter and its surroundings: requester command/response
// signals, the AXI master command port, and arbiter status.
interface axi_master_arbiter_if;
    // Requester handshake: reqN_valid with its fields stays stable until a one-cycle reqN_ack;
    // reqN_err/reqN_rdata are meaningful in the ack cycle. The master accepts a start pulse
    // only while m_done=1 and raises m_done again when the command has finished.
    logic        req0_valid;
    logic        req0_write;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ack;
    logic        req0_err;
    logic [31:0] req0_rdata;

    logic        req1_valid;
    logic        req1_write;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ack;
    logic        req1_err;
    logic [31:0] req1_rdata;

    logic [31:0] m_addr;
    logic [31:0] m_write_data;
    logic        m_start_write;
    logic        m_start_read;
    logic        m_done;
    logic [31:0] m_read_data;

    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  dbg_state;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  m_done, m_read_data,
        output req0_ack, req0_err, req0_rdata,
        output req1_ack, req1_err, req1_rdata,
        output m_addr, m_write_data, m_start_write, m_start_read,
        output grant, busy, timeout_err, dbg_state
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output m_done, m_read_data,
        input  req0_ack, req0_err, req0_rdata,
        input  req1_ack, req1_err, req1_rdata,
        input  m_addr, m_write_data, m_start_write, m_start_read,
        input  grant, busy, timeout_err, dbg_state
    );
endinterface

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one AXI master command port between two requesters,
// with a per-transfer timeout that aborts the command and reports an error.
module axi_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESETN,
    axi_master_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic        cmd_write_q, cmd_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        start_w_q, start_w_d;
    logic        start_r_q, start_r_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic        terr_q, terr_d;
    logic        pick1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cmd_write_d = cmd_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        start_w_d   = 1'b0;
        start_r_d   = 1'b0;
        cnt_d       = cnt_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        busy_d      = busy_q;
        terr_d      = terr_q;
        // last_q holds the index of the requester served most recently
        pick1       = bus.req1_valid && (!bus.req0_valid || !last_q);

        case (state_q)
            S_IDLE: begin
                if (bus.m_done && (bus.req0_valid || bus.req1_valid)) begin
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    cmd_write_d = pick1 ? bus.req1_write : bus.req0_write;
                    addr_d      = pick1 ? bus.req1_addr  : bus.req0_addr;
                    wdata_d     = pick1 ? bus.req1_wdata : bus.req0_wdata;
                    start_w_d   = pick1 ? bus.req1_write  : bus.req0_write;
                    start_r_d   = pick1 ? !bus.req1_write : !bus.req0_write;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                // m_done may still show the previous idle level here, so it is not sampled
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.m_done) begin
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    state_d = S_RESP;
                    if (!cmd_write_q && grant_q[0]) rdata0_d = bus.m_read_data;
                    if (!cmd_write_q && grant_q[1]) rdata1_d = bus.m_read_data;
                end else if (cnt_q == CNT_LAST) begin
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    err0_d  = grant_q[0];
                    err1_d  = grant_q[1];
                    terr_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            cmd_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            start_w_q   <= 1'b0;
            start_r_q   <= 1'b0;
            cnt_q       <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cmd_write_q <= cmd_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            start_w_q   <= start_w_d;
            start_r_q   <= start_r_d;
            cnt_q       <= cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    assign bus.req0_ack      = ack0_q;
    assign bus.req0_err      = err0_q;
    assign bus.req0_rdata    = rdata0_q;
    assign bus.req1_ack      = ack1_q;
    assign bus.req1_err      = err1_q;
    assign bus.req1_rdata    = rdata1_q;
    assign bus.m_addr        = addr_q;
    assign bus.m_write_data  = wdata_q;
    assign bus.m_start_write = start_w_q;
    assign bus.m_start_read  = start_r_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = terr_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: two requester drivers, a behavioural AXI master, a
// transaction-level reference model checked every cycle, and directed scenarios.
module tb_axi_master_arbiter;
    localparam int TO = 8;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    axi_master_arbiter_if bus ();

    axi_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .bus          (bus.master)
    );

    // clock
    always #5 clk = ~clk;

    cmd_t        cmd_q0[$];
    cmd_t        cmd_q1[$];
    logic [1:0]  exp_q[$];
    logic [1:0]  grant_log[$];

    int          mst_busy      = 1;
    bit          mst_hang      = 1'b0;
    bit          mst_idle_done = 1'b1;
    logic [31:0] mst_rdata     = '0;

    int cyc = 0;
    int gnt_cyc = 0;
    int ack_cyc = 0;
    int n_ack0 = 0;
    int n_ack1 = 0;
    int n_start_w = 0;
    int n_start_r = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // requester 0: holds a command until ack, then loads the next queued one
    initial begin
        cmd_t c;
        bit   ack_seen;
        bus.req0_valid = 1'b0;
        bus.req0_write = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        forever begin
            @(negedge clk);
            ack_seen = bus.req0_ack;
            @(posedge clk);
            #1;
            if (ack_seen) bus.req0_valid = 1'b0;
            if (!bus.req0_valid && cmd_q0.size() > 0) begin
                c = cmd_q0.pop_front();
                bus.req0_write = c.write;
                bus.req0_addr  = c.addr;
                bus.req0_wdata = c.wdata;
                bus.req0_valid = 1'b1;
            end
        end
    end

    initial begin
        cmd_t c;
        bit   ack_seen;
        bus.req1_valid = 1'b0;
        bus.req1_write = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        forever begin
            @(negedge clk);
            ack_seen = bus.req1_ack;
            @(posedge clk);
            #1;
            if (ack_seen) bus.req1_valid = 1'b0;
            if (!bus.req1_valid && cmd_q1.size() > 0) begin
                c = cmd_q1.pop_front();
                bus.req1_write = c.write;
                bus.req1_addr  = c.addr;
                bus.req1_wdata = c.wdata;
                bus.req1_valid = 1'b1;
            end
        end
    end

    // behavioural master: m_done drops after a start, returns after mst_busy cycles unless hung
    initial begin
        bit st;
        bit active;
        int left;
        active = 1'b0;
        left = 0;
        bus.m_done = 1'b1;
        bus.m_read_data = '0;
        forever begin
            @(negedge clk);
            st = rst_n && (bus.m_start_write || bus.m_start_read);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active = 1'b0;
                bus.m_done = mst_idle_done;
            end else if (st) begin
                active = 1'b1;
                left = mst_busy;
                bus.m_done = 1'b0;
            end else if (active) begin
                if (!mst_hang) begin
                    left--;
                    if (left <= 0) begin
                        active = 1'b0;
                        bus.m_done = 1'b1;
                        bus.m_read_data = mst_rdata;
                    end
                end
            end else begin
                bus.m_done = mst_idle_done;
            end
        end
    end

    // reference model: who owns the master, how far the transfer has progressed
    int          mo_owner;
    int          mo_age;
    int          mo_waits;
    bit          mo_resp;
    bit          mo_err;
    int          mo_last;
    bit          mo_terr;
    bit          mo_write;
    logic [31:0] mo_addr;
    logic [31:0] mo_wdata;
    logic [31:0] mo_rdata[2];

    task automatic model_reset();
        mo_owner = -1;
        mo_age = 0;
        mo_waits = 0;
        mo_resp = 1'b0;
        mo_err = 1'b0;
        mo_last = 1;
        mo_terr = 1'b0;
        mo_write = 1'b0;
        mo_addr = '0;
        mo_wdata = '0;
        mo_rdata[0] = '0;
        mo_rdata[1] = '0;
    endtask

    task automatic model_step();
        if (mo_owner < 0) begin
            if (bus.m_done && (bus.req0_valid || bus.req1_valid)) begin
                if (bus.req0_valid && bus.req1_valid) mo_owner = 1 - mo_last;
                else mo_owner = bus.req1_valid ? 1 : 0;
                mo_age = 0;
                mo_resp = 1'b0;
                mo_write = (mo_owner == 0) ? bus.req0_write : bus.req1_write;
                mo_addr  = (mo_owner == 0) ? bus.req0_addr  : bus.req1_addr;
                mo_wdata = (mo_owner == 0) ? bus.req0_wdata : bus.req1_wdata;
            end
        end else if (mo_resp) begin
            mo_last = mo_owner;
            mo_owner = -1;
            mo_resp = 1'b0;
            mo_err = 1'b0;
        end else if (mo_age < 2) begin
            mo_age++;
            mo_waits = 0;
        end else if (bus.m_done) begin
            mo_resp = 1'b1;
            mo_err = 1'b0;
            if (!mo_write) mo_rdata[mo_owner] = bus.m_read_data;
        end else if (mo_waits == TO - 1) begin
            mo_resp = 1'b1;
            mo_err = 1'b1;
            mo_terr = 1'b1;
        end else begin
            mo_waits++;
        end
    endtask

    // scoreboard: every cycle the DUT outputs are compared against the model
    initial begin
        logic [1:0] prev_grant;
        logic [1:0] exp_grant;
        logic [3:0] exp_resp;
        bit         own0;
        bit         own1;
        bit         issuing;
        prev_grant = 2'b00;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) model_reset();
            own0 = (mo_owner == 0);
            own1 = (mo_owner == 1);
            issuing = (mo_owner >= 0) && (mo_age == 0) && !mo_resp;
            exp_grant = {own1, own0};
            exp_resp = {mo_resp && own1, mo_resp && own1 && mo_err,
                        mo_resp && own0, mo_resp && own0 && mo_err};
            check("grant", bus.grant, exp_grant);
            check("busy", bus.busy, mo_owner >= 0);
            check("start_w", bus.m_start_write, issuing && mo_write);
            check("start_r", bus.m_start_read, issuing && !mo_write);
            check("ack_err", {bus.req1_ack, bus.req1_err, bus.req0_ack, bus.req0_err}, exp_resp);
            check("m_addr", bus.m_addr, mo_addr);
            check("m_wdata", bus.m_write_data, mo_wdata);
            check("rdata0", bus.req0_rdata, mo_rdata[0]);
            check("rdata1", bus.req1_rdata, mo_rdata[1]);
            check("timeout_err", bus.timeout_err, mo_terr);
            if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
                grant_log.push_back(bus.grant);
                gnt_cyc = cyc;
            end
            prev_grant = bus.grant;
            if (bus.req0_ack) begin n_ack0++; ack_cyc = cyc; end
            if (bus.req1_ack) begin n_ack1++; ack_cyc = cyc; end
            if (bus.m_start_write) n_start_w++;
            if (bus.m_start_read) n_start_r++;
            if (rst_n) model_step();
        end
    end

    task automatic wait_start(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.m_start_write || bus.m_start_read) break;
        end
        check("start_seen", i < budget, 1'b1);
    endtask

    task automatic wait_ack(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((n == 0 && bus.req0_ack) || (n == 1 && bus.req1_ack)) break;
        end
        check("ack_seen", i < budget, 1'b1);
        #1;
    endtask

    task automatic wait_n_acks(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_ack0 + n_ack1 >= target) break;
        end
        check("acks_seen", i < budget, 1'b1);
    endtask

    initial begin
        int sw;
        int sr;
        int base;
        int na;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", bus.grant, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rdata0", bus.req0_rdata, 32'h0);
        check("rst_terr", bus.timeout_err, 1'b0);
        rst_n = 1'b1;

        // single write, master busy 4 cycles
        mst_busy = 4;
        mst_rdata = 32'hFFFF_0000;
        sw = n_start_w;
        sr = n_start_r;
        cmd_q0.push_back({1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
        wait_start(20);
        check("a_start_w", bus.m_start_write, 1'b1);
        check("a_addr", bus.m_addr, 32'h0000_0010);
        check("a_wdata", bus.m_write_data, 32'hDEAD_BEEF);
        wait_ack(0, 30);
        check("a_err", bus.req0_err, 1'b0);
        check("a_latency", ack_cyc - gnt_cyc, 6);
        check("a_nstart_w", n_start_w - sw, 1);
        check("a_nstart_r", n_start_r - sr, 0);
        repeat (3) @(negedge clk);

        // single read on requester 1
        mst_busy = 2;
        mst_rdata = 32'h1234_5678;
        sw = n_start_w;
        sr = n_start_r;
        cmd_q1.push_back({1'b0, 32'h0000_0020, 32'h0});
        wait_ack(1, 30);
        check("b_rdata", bus.req1_rdata, 32'h1234_5678);
        check("b_latency", ack_cyc - gnt_cyc, 4);
        check("b_nstart_r", n_start_r - sr, 1);
        check("b_nstart_w", n_start_w - sw, 0);
        repeat (5) @(negedge clk);
        check("b_hold", bus.req1_rdata, 32'h1234_5678);

        // simultaneous requests, each reissuing once
        mst_busy = 1;
        mst_rdata = 32'h0BAD_F00D;
        base = grant_log.size();
        na = n_ack0 + n_ack1;
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
        cmd_q0.push_back({1'b1, 32'h0000_0100, 32'h1111_0000});
        cmd_q0.push_back({1'b1, 32'h0000_0104, 32'h1111_0004});
        cmd_q1.push_back({1'b0, 32'h0000_0200, 32'h0});
        cmd_q1.push_back({1'b0, 32'h0000_0204, 32'h0});
        wait_n_acks(na + 4, 80);
        check("c_ngrants", grant_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < grant_log.size()) check("c_order", grant_log[base + i], exp_q[i]);
        end
        check("c_latency", ack_cyc - gnt_cyc, 3);
        check("c_rdata1", bus.req1_rdata, 32'h0BAD_F00D);
        repeat (3) @(negedge clk);

        // master hangs: timeout abort, then no grant until m_done returns
        mst_hang = 1'b1;
        mst_busy = 2;
        mst_rdata = 32'hA5A5_0001;
        cmd_q0.push_back({1'b0, 32'h0000_0040, 32'h0});
        cmd_q0.push_back({1'b0, 32'h0000_0044, 32'h0});
        wait_ack(0, 40);
        check("d_err", bus.req0_err, 1'b1);
        check("d_terr", bus.timeout_err, 1'b1);
        check("d_latency", ack_cyc - gnt_cyc, 10);
        repeat (5) begin
            @(negedge clk);
            check("d_nogrant", bus.grant, 2'b00);
        end
        check("d_pending", bus.req0_valid, 1'b1);
        mst_hang = 1'b0;
        wait_ack(0, 30);
        check("d2_err", bus.req0_err, 1'b0);
        check("d2_rdata", bus.req0_rdata, 32'hA5A5_0001);
        check("d2_terr", bus.timeout_err, 1'b1);
        repeat (3) @(negedge clk);

        // reset in the middle of WAIT
        mst_hang = 1'b1;
        mst_busy = 1;
        cmd_q1.push_back({1'b1, 32'h0000_0080, 32'h0000_0055});
        wait_start(20);
        repeat (4) @(negedge clk);
        na = n_ack1;
        #2 rst_n = 1'b0;
        #1;
        check("e_grant", bus.grant, 2'b00);
        check("e_busy", bus.busy, 1'b0);
        check("e_addr", bus.m_addr, 32'h0);
        check("e_wdata", bus.m_write_data, 32'h0);
        check("e_terr", bus.timeout_err, 1'b0);
        check("e_rdata0", bus.req0_rdata, 32'h0);
        check("e_ack", {bus.req1_ack, bus.req0_ack}, 2'b00);
        repeat (2) @(posedge clk);
        mst_hang = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("e_noack", n_ack1 - na, 0);
        base = grant_log.size();
        wait_ack(1, 30);
        check("e_regrant_cnt", grant_log.size() - base, 1);
        if (grant_log.size() > base) check("e_regrant", grant_log[base], 2'b10);
        check("e_latency", ack_cyc - gnt_cyc, 3);
        repeat (3) @(negedge clk);

        // master not idle: request must wait
        mst_idle_done = 1'b0;
        base = grant_log.size();
        cmd_q0.push_back({1'b1, 32'h0000_0300, 32'h0000_0077});
        repeat (6) begin
            @(negedge clk);
            check("f_nogrant", bus.grant, 2'b00);
            check("f_nostart", {bus.m_start_write, bus.m_start_read}, 2'b00);
        end
        mst_idle_done = 1'b1;
        wait_ack(0, 30);
        check("f_err", bus.req0_err, 1'b0);
        check("f_grants", grant_log.size() - base, 1);
        if (grant_log.size() > base) check("f_grant", grant_log[base], 2'b01);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_master_arbiter.md
AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, range 2..65535: max cycles allowed in WAIT before a transfer is aborted.
REQ-002 M_AXI_ACLK  input  1  sole clock; all logic on its rising edge.
REQ-003 M_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-004 reqN_valid (N=0,1)  input  1  requester N has a pending command.
REQ-005 reqN_write  input  1  1 = write, 0 = read.
REQ-006 reqN_addr  input  32  command address.
REQ-007 reqN_wdata  input  32  write data (ignored for reads).
REQ-008 reqN_ack  output  1  one-cycle completion pulse to requester N.
REQ-009 reqN_err  output  1  valid with reqN_ack; 1 = aborted by timeout.
REQ-010 reqN_rdata  output  32  read result, valid with reqN_ack, held until next ack to N.
REQ-011 m_addr  output  32  address to the AXI master command port.
REQ-012 m_write_data  output  32  write data to the master.
REQ-013 m_start_write / m_start_read  output  1 each  one-cycle start pulses to the master.
REQ-014 m_done  input  1  master idle indication (1 = idle, ready for start).
REQ-015 m_read_data  input  32  master read result.
REQ-016 grant  output  2  one-hot owner of the master; 00 when none.
REQ-017 busy  output  1  1 in any state other than IDLE.
REQ-018 timeout_err  output  1  sticky flag, set on any timeout abort.

Function
REQ-019 FSM states IDLE, ISSUE, LAUNCH, WAIT, RESP; exactly one active.
REQ-020 IDLE: if m_done=1 and any reqN_valid=1, grant per REQ-021, latch that requester's write/addr/wdata into internal command registers, set grant, go ISSUE; with m_done=0 no grant is made.
REQ-021 Arbitration round-robin: one valid -> it wins; both valid -> requester not granted last wins; last-grant register resets to 1 so req0 wins the first tie.
REQ-022 ISSUE (exactly 1 cycle): m_addr/m_write_data driven from command registers; m_start_write=1 if write else m_start_read=1; go LAUNCH.
REQ-023 LAUNCH (exactly 1 cycle): no start, m_done ignored; clear timeout counter; go WAIT.
REQ-024 WAIT: m_done=1 -> capture m_read_data (reads only), go RESP with err=0; else increment 16-bit counter; counter = TIMEOUT_CYCLES-1 with m_done=0 -> go RESP with err=1, set timeout_err.
REQ-025 RESP (exactly 1 cycle): pulse reqN_ack for granted N, reqN_err per REQ-024, update reqN_rdata on reads only, record last-grant=N, clear grant, go IDLE.
REQ-026 m_addr/m_write_data hold command register values from ISSUE through RESP; start pulses are 0 outside ISSUE.
REQ-027 Requester protocol: reqN_valid and fields held stable until reqN_ack; requester deasserts valid on the edge it samples ack; valid without ack is never dropped by the arbiter.
REQ-028 Non-granted request stays pending; arbiter never acks a request it did not issue.
REQ-029 Minimum latency, grant edge to ack: 3 cycles plus master busy time; back-to-back grants separated by at least one IDLE cycle.
REQ-030 After timeout abort, no new grant until m_done=1 (REQ-020).

Reset
REQ-031 M_AXI_ARESETN=0 immediately forces IDLE, grant=00, busy=0, all ack/err/start=0, timeout_err=0, reqN_rdata=0, m_addr=0, m_write_data=0, counter=0, last-grant=1; in-flight command is dropped without ack.
REQ-032 Deassertion takes effect at the next rising edge; first grant no earlier than that edge.

Verification
REQ-033 req0 write addr=0x0000_0010 wdata=0xDEAD_BEEF, m_done returns 1 after 4 cycles -> one m_start_write pulse with m_addr=0x10, m_write_data=0xDEADBEEF; req0_ack=1, req0_err=0.
REQ-034 req1 read addr=0x20, master returns 0x1234_5678 -> one m_start_read, req1_rdata=0x12345678 at req1_ack.
REQ-035 req0 and req1 valid same cycle, each reissuing after ack, 4 transfers -> grant order 01,10,01,10.
REQ-036 TIMEOUT_CYCLES=8, m_done held 0 after start -> reqN_ack with reqN_err=1 after 8 WAIT cycles, timeout_err=1 sticky; no grant until m_done=1.
REQ-037 Reset asserted during WAIT -> outputs per REQ-031 at once, no ack issued; pending request re-granted after reset release.
REQ-038 m_done=0 in IDLE with req0_valid=1 -> grant stays 00, no start, until m_done=1.
